// File: rtl/noise_check.sv
// noise_check: self-synchronising checker for the 24-bit LFSR noise stream (taps 23,3,2,0; sample = state[23:8])
// clk_i, rst_i (async, active-high); valid_i/data_i: incoming samples; clear_i: clear statistics
// locked_o: model synchronised; sample_cnt_o/err_cnt_o/bit_err_cnt_o: saturating statistics while locked
module noise_check #(
  parameter int LOSS_THRESH = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [15:0]      data_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic [CNT_W-1:0] sample_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] bit_err_cnt_o
);
  typedef enum logic [1:0] {ACQ_HI, ACQ_LO, LOCK} state_t;
  localparam int MW = $clog2(LOSS_THRESH + 1);
  state_t st, st_d;
  logic [23:0] m, m_d, s0, s8, pred;
  logic [15:0] prev, prev_d, diff;
  logic [2:0] acq, acq_d;
  logic [MW-1:0] miss, miss_d;
  logic lock_d;
  logic [CNT_W-1:0] sc_d, ec_d, bc_d;
  logic [CNT_W:0] bsum;
  function automatic logic [23:0] step(input logic [23:0] s);
    return {s[22:0], s[23] ^ s[3] ^ s[2] ^ s[0]};
  endfunction
  function automatic logic [4:0] popcnt(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction
  always_comb begin
    st_d   = st;
    m_d    = m;
    prev_d = prev;
    acq_d  = acq;
    miss_d = miss;
    lock_d = locked_o;
    sc_d   = sample_cnt_o;
    ec_d   = err_cnt_o;
    bc_d   = bit_err_cnt_o;
    pred   = step(m);
    diff   = data_i ^ pred[23:8];
    bsum   = {1'b0, bit_err_cnt_o} + (CNT_W+1)'(popcnt(diff));
    // each ACQ_LO sample contributes the next unseen low bit of the first sample's state
    s0     = m;
    s0[3'd7 - acq] = data_i[0];
    s8     = s0;
    for (int i = 0; i < 8; i++) s8 = step(s8);
    if (valid_i) begin
      prev_d = data_i;
      case (st)
        ACQ_HI: begin
          m_d   = {data_i, 8'h00};
          acq_d = '0;
          st_d  = ACQ_LO;
        end
        ACQ_LO: begin
          if (data_i[15:1] != prev[14:0]) begin
            m_d   = {data_i, 8'h00};
            acq_d = '0;
          end else if (acq == 3'd7) begin
            // all-zero state is the LFSR lock-up point and never produces a valid stream
            st_d   = (s0 == '0) ? ACQ_HI : LOCK;
            m_d    = (s0 == '0) ? s0 : s8;
            lock_d = (s0 != '0);
            acq_d  = '0;
            miss_d = '0;
          end else begin
            m_d   = s0;
            acq_d = acq + 3'd1;
          end
        end
        LOCK: begin
          m_d  = pred;
          sc_d = &sample_cnt_o ? sample_cnt_o : sample_cnt_o + 1'b1;
          if (diff != '0) begin
            ec_d   = &err_cnt_o ? err_cnt_o : err_cnt_o + 1'b1;
            bc_d   = bsum[CNT_W] ? '1 : bsum[CNT_W-1:0];
            miss_d = miss + 1'b1;
            if (int'(miss_d) == LOSS_THRESH) begin
              st_d   = ACQ_HI;
              lock_d = 1'b0;
              miss_d = '0;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: st_d = ACQ_HI;
      endcase
    end
    if (clear_i) begin
      sc_d = '0;
      ec_d = '0;
      bc_d = '0;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st            <= ACQ_HI;
      m             <= '0;
      prev          <= '0;
      acq           <= '0;
      miss          <= '0;
      locked_o      <= 1'b0;
      sample_cnt_o  <= '0;
      err_cnt_o     <= '0;
      bit_err_cnt_o <= '0;
    end else begin
      st            <= st_d;
      m             <= m_d;
      prev          <= prev_d;
      acq           <= acq_d;
      miss          <= miss_d;
      locked_o      <= lock_d;
      sample_cnt_o  <= sc_d;
      err_cnt_o     <= ec_d;
      bit_err_cnt_o <= bc_d;
    end
  end
endmodule

// File: tb/tb_noise_check.sv
// tb_noise_check: scoreboard bench for noise_check driven from the reference LFSR stream
module tb_noise_check;
  logic clk_i = 1'b0;
  logic rst_i, valid_i, clear_i, locked_o;
  logic [15:0] data_i;
  logic [31:0] sample_cnt_o, err_cnt_o, bit_err_cnt_o;
  typedef struct {logic lk; logic [31:0] s, e, b;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [23:0] g;
  bit duty, xl;
  int run, miss;
  logic [31:0] xs, xe, xb;
  logic v_seen;
  noise_check #(.LOSS_THRESH(4), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i), .clear_i(clear_i),
    .locked_o(locked_o), .sample_cnt_o(sample_cnt_o), .err_cnt_o(err_cnt_o), .bit_err_cnt_o(bit_err_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i or posedge rst_i) v_seen <= rst_i ? 1'b0 : valid_i;
  function automatic logic [23:0] step(input logic [23:0] s);
    return {s[22:0], s[23] ^ s[3] ^ s[2] ^ s[0]};
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask
  always @(negedge clk_i) begin
    if (v_seen) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard underflow at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("locked", {31'd0, locked_o}, {31'd0, e.lk});
        chk("sample_cnt", sample_cnt_o, e.s);
        chk("err_cnt", err_cnt_o, e.e);
        chk("bit_err_cnt", bit_err_cnt_o, e.b);
      end
    end
  end
  task automatic idle();
    @(negedge clk_i);
    valid_i = 1'b0;
    clear_i = 1'b0;
    data_i  = 16'($urandom);
  endtask
  task automatic send(input logic [15:0] flip, input bit clr);
    if (duty) for (int k = 0; k < 20 && $urandom_range(0, 99) >= 30; k++) idle();
    @(negedge clk_i);
    valid_i = 1'b1;
    clear_i = clr;
    data_i  = g[23:8] ^ flip;
    g = step(g);
    if (xl) begin
      if (!clr) begin
        xs++;
        if (flip != 0) begin
          xe++;
          xb += $countones(flip);
        end
      end
      miss = (flip != 0) ? miss + 1 : 0;
      if (miss == 4) begin
        xl = 0;
        miss = 0;
        run = 0;
      end
    end else begin
      run++;
      if (run == 9) begin
        xl = 1;
        miss = 0;
      end
    end
    if (clr) begin
      xs = 0;
      xe = 0;
      xb = 0;
    end
    q.push_back('{xl, xs, xe, xb});
  endtask
  task automatic send_raw(input logic [15:0] d);
    @(negedge clk_i);
    valid_i = 1'b1;
    clear_i = 1'b0;
    data_i  = d;
    q.push_back('{xl, xs, xe, xb});
  endtask
  task automatic do_reset();
    @(negedge clk_i);
    valid_i = 1'b0;
    clear_i = 1'b0;
    rst_i   = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_locked", {31'd0, locked_o}, 32'd0);
    chk("rst_sample_cnt", sample_cnt_o, 32'd0);
    chk("rst_err_cnt", err_cnt_o, 32'd0);
    chk("rst_bit_err_cnt", bit_err_cnt_o, 32'd0);
    xl = 0; run = 0; miss = 0; xs = 0; xe = 0; xb = 0;
  endtask
  task automatic acquire();
    repeat (8) send(16'h0000, 1'b0);
    idle();
    chk("pre_lock", {31'd0, locked_o}, 32'd0);
    send(16'h0000, 1'b0);
    idle();
    chk("lock", {31'd0, locked_o}, 32'd1);
  endtask
  initial begin
    rst_i = 1'b1; valid_i = 1'b0; clear_i = 1'b0; data_i = '0; duty = 0;
    xl = 0; run = 0; miss = 0; xs = 0; xe = 0; xb = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk("init_locked", {31'd0, locked_o}, 32'd0);
    chk("init_sample_cnt", sample_cnt_o, 32'd0);
    g = 24'h8964CE;
    chk("first_sample", {16'd0, g[23:8]}, 32'h8964);
    acquire();
    repeat (1000) send(16'h0000, 1'b0);
    idle();
    chk("t1_samples", sample_cnt_o, 32'd1000);
    chk("t1_err", err_cnt_o, 32'd0);
    send(16'h0001, 1'b0);
    repeat (20) send(16'h0000, 1'b0);
    idle();
    chk("t2_err", err_cnt_o, 32'd1);
    chk("t2_bit_err", bit_err_cnt_o, 32'd1);
    chk("t2_locked", {31'd0, locked_o}, 32'd1);
    send(16'h0000, 1'b1);
    idle();
    chk("clr_samples", sample_cnt_o, 32'd0);
    chk("clr_err", err_cnt_o, 32'd0);
    chk("clr_locked", {31'd0, locked_o}, 32'd1);
    repeat (3) send(16'hFFFF, 1'b0);
    idle();
    chk("t3_still_locked", {31'd0, locked_o}, 32'd1);
    send(16'hFFFF, 1'b0);
    idle();
    chk("t3_lost", {31'd0, locked_o}, 32'd0);
    chk("t3_err", err_cnt_o, 32'd4);
    chk("t3_bit_err", bit_err_cnt_o, 32'd64);
    acquire();
    chk("t3_retained", err_cnt_o, 32'd4);
    do_reset();
    g = 24'h8964CE;
    duty = 1;
    acquire();
    repeat (200) send(16'h0000, 1'b0);
    duty = 0;
    idle();
    chk("t4_samples", sample_cnt_o, 32'd200);
    chk("t4_err", err_cnt_o, 32'd0);
    do_reset();
    repeat (100) send_raw(16'h0000);
    idle();
    chk("t5_locked", {31'd0, locked_o}, 32'd0);
    chk("t5_samples", sample_cnt_o, 32'd0);
    do_reset();
    g = 24'h8964CE;
    repeat (5) send(16'h0000, 1'b0);
    do_reset();
    acquire();
    idle();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover entries=%0d", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
